// File: rtl/fifo_wr_ctrl_mem_if.sv
// Write-side port bundle of the async FIFO: write request/data, the read-domain pointer and
// read address coming in, and storage read data, write pointer and fill flags going out.
interface fifo_wr_ctrl_mem_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
);
   logic                  W_INC;
   logic [DATA_WIDTH-1:0] WR_DATA;
   logic [ADDR_WIDTH:0]   R_PTR_GRAY;
   logic [ADDR_WIDTH-1:0] R_addr;
   logic                  OVF_CLR;
   logic [DATA_WIDTH-1:0] RD_DATA;
   logic [ADDR_WIDTH:0]   W_PTR_GRAY;
   logic [ADDR_WIDTH-1:0] W_addr;
   logic                  FULL;
   logic                  ALMOST_FULL;
   logic [ADDR_WIDTH:0]   W_LEVEL;
   logic                  OVERFLOW;

   modport slave (
      input  W_INC, WR_DATA, R_PTR_GRAY, R_addr, OVF_CLR,
      output RD_DATA, W_PTR_GRAY, W_addr, FULL, ALMOST_FULL, W_LEVEL, OVERFLOW
   );

   modport master (
      output W_INC, WR_DATA, R_PTR_GRAY, R_addr, OVF_CLR,
      input  RD_DATA, W_PTR_GRAY, W_addr, FULL, ALMOST_FULL, W_LEVEL, OVERFLOW
   );
endinterface

// File: rtl/fifo_wr_ctrl_mem.sv
// Write-domain half of an async FIFO: dual-port storage, binary/Gray write pointer,
// read-pointer synchroniser and registered full/almost-full/level/overflow flags.
module fifo_wr_ctrl_mem #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 3,
   parameter int AF_THRESH   = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 W_CLK,
   input  logic                 W_RST,
   fifo_wr_ctrl_mem_if.slave    bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int PW    = ADDR_WIDTH + 1;
   // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
   localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

   function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   logic [PW-1:0]         wptr_bin_q, wptr_bin_d;
   logic [PW-1:0]         wptr_gray_q, wptr_gray_d;
   logic [PW-1:0]         sync_q [SYNC_STAGES];
   logic [PW-1:0]         rq_gray, rq_bin;
   logic [PW-1:0]         level_q, level_d;
   logic                  full_q, full_d;
   logic                  af_q, af_d;
   logic                  ovf_q, ovf_d;
   logic                  we;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_comb begin
      we          = bus.W_INC & ~full_q;
      wptr_bin_d  = wptr_bin_q + PW'(we);
      wptr_gray_d = bin2gray(wptr_bin_d);
      rq_gray     = sync_q[SYNC_STAGES-1];
      rq_bin      = gray2bin(rq_gray);
      full_d      = (wptr_gray_d == (rq_gray ^ FULL_MASK));
      level_d     = wptr_bin_d - rq_bin;
      af_d        = (level_d >= PW'(AF_THRESH));
      // A blocked write re-arms the sticky flag even if a clear arrives the same cycle.
      ovf_d       = ovf_q;
      if (bus.W_INC & full_q) ovf_d = 1'b1;
      else if (bus.OVF_CLR)   ovf_d = 1'b0;
   end

   always_ff @(posedge W_CLK or negedge W_RST) begin
      if (!W_RST) begin
         wptr_bin_q  <= '0;
         wptr_gray_q <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         level_q     <= '0;
         full_q      <= 1'b0;
         af_q        <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         wptr_bin_q  <= wptr_bin_d;
         wptr_gray_q <= wptr_gray_d;
         sync_q[0]   <= bus.R_PTR_GRAY;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         level_q     <= level_d;
         full_q      <= full_d;
         af_q        <= af_d;
         ovf_q       <= ovf_d;
      end
   end

   always_ff @(posedge W_CLK or negedge W_RST) begin
      if (!W_RST) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (we) begin
         mem_q[wptr_bin_q[ADDR_WIDTH-1:0]] <= bus.WR_DATA;
      end
   end

   assign bus.RD_DATA     = mem_q[bus.R_addr];
   assign bus.W_PTR_GRAY  = wptr_gray_q;
   assign bus.W_addr      = wptr_bin_q[ADDR_WIDTH-1:0];
   assign bus.FULL        = full_q;
   assign bus.ALMOST_FULL = af_q;
   assign bus.W_LEVEL     = level_q;
   assign bus.OVERFLOW    = ovf_q;
endmodule
